// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring shift-subtract,
// both on operand magnitudes; signs are applied in a final fix-up cycle.
// Latency is fixed at WIDTH+1 edges after the accepting edge.
module mips_muldiv #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               op_div_q, op_div_d;
  // Multiply: {upper partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_b_q, mag_b_d;
  // Product sign (multiply) or quotient sign (divide).
  logic               neg_res_q, neg_res_d;
  // Remainder follows the dividend's sign.
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  // Request decode and operand magnitudes.
  logic             op_signed;
  logic             op_is_div;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign op_signed = ~op[0];
  assign op_is_div = op[1];
  assign mag_a     = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b     = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // One shift-add multiply step.
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_addend = acc_q[0] ? mag_b_q : '0;
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_next   = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step; the borrow bit of the trial subtract picks restore or keep.
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_next;

  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_diff = rem_sh - {1'b0, mag_b_q};
  assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign fix-up of the finished magnitudes.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_mag = acc_q[WIDTH-1:0];
  assign rem_mag  = acc_q[2*WIDTH-1:WIDTH];
  assign quot_fix = neg_res_q ? -quot_mag : quot_mag;
  assign rem_fix  = neg_rem_q ? -rem_mag : rem_mag;

  // Next-state logic: request acceptance, iteration, fix-up and HI/LO writes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_div_d  = op_div_q;
    acc_d     = acc_q;
    mag_b_d   = mag_b_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !flush) begin
          if (op_is_div && (src_b == '0)) begin
            // Divide by zero finishes immediately and overrides any MTHI/MTLO.
            hi_d   = src_a;
            lo_d   = '1;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d   = StCalc;
            cnt_d     = CntW'(WIDTH - 1);
            busy_d    = 1'b1;
            dbz_d     = 1'b0;
            op_div_d  = op_is_div;
            acc_d     = {{WIDTH{1'b0}}, mag_a};
            mag_b_d   = mag_b;
            neg_res_d = op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem_d = op_signed & src_a[WIDTH-1];
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = op_div_q ? div_next : mul_next;
          if (cnt_q == '0) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        if (!flush) begin
          if (op_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_div_q  <= 1'b0;
      acc_q     <= '0;
      mag_b_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_div_q  <= op_div_d;
      acc_q     <= acc_d;
      mag_b_q   <= mag_b_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: arithmetic reference model checked every cycle, plus
// directed literal checks and a randomized phase; a second instance at WIDTH=8.
module tb_mips_muldiv;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         flush = 1'b0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  logic         start8 = 1'b0;
  logic [1:0]   op8 = 2'b00;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic         busy8, done8, dbz8;
  logic [7:0]   hi8, lo8;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_dz = 1'b0;
  logic [W-1:0] pend_hi = '0;
  logic [W-1:0] pend_lo = '0;
  int           left = 0;

  always #5 clk = ~clk;

  mips_muldiv #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .src_a       (src_a),
    .src_b       (src_b),
    .flush       (flush),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  mips_muldiv #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start8),
    .op          (op8),
    .src_a       (a8),
    .src_b       (b8),
    .flush       (1'b0),
    .hi_we       (1'b0),
    .lo_we       (1'b0),
    .wdata       (8'h00),
    .busy        (busy8),
    .done        (done8),
    .div_by_zero (dbz8),
    .hi          (hi8),
    .lo          (lo8)
  );

  // Architectural result of one operation, computed with plain integer arithmetic.
  function automatic void ref_op(input int w, input logic [1:0] o, input longint a,
                                 input longint b, output longint rh, output longint rl,
                                 output bit dz);
    longint mask, half, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa   = (a >= half) ? a - (longint'(1) << w) : a;
    sb   = (b >= half) ? b - (longint'(1) << w) : b;
    dz   = 1'b0;
    rh   = 0;
    rl   = 0;
    case (o)
      2'd0: begin p = sa * sb; rh = (p >>> w) & mask; rl = p & mask; end
      2'd1: begin p = a * b;   rh = (p >> w) & mask;  rl = p & mask; end
      2'd2: begin
        if (b == 0) begin
          rh = a; rl = mask; dz = 1'b1;
        end else begin
          q = sa / sb; r = sa % sb; rh = r & mask; rl = q & mask;
        end
      end
      default: begin
        if (b == 0) begin
          rh = a; rl = mask; dz = 1'b1;
        end else begin
          q = a / b; r = a % b; rh = r & mask; rl = q & mask;
        end
      end
    endcase
  endfunction

  // Cycle model: an accepted op finishes W+1 edges later unless flushed.
  initial begin
    longint rh, rl;
    bit     dz;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; left = 0;
      end else begin
        m_done = 1'b0;
        if (left > 0) begin
          if (flush) begin
            left = 0;
          end else begin
            left = left - 1;
            if (left == 0) begin
              m_hi = pend_hi; m_lo = pend_lo; m_done = 1'b1;
            end
          end
        end else begin
          if (hi_we) m_hi = wdata;
          if (lo_we) m_lo = wdata;
          if (start && !flush) begin
            ref_op(W, op, longint'(src_a), longint'(src_b), rh, rl, dz);
            if (dz) begin
              m_hi = rh[W-1:0]; m_lo = rl[W-1:0]; m_dz = 1'b1; m_done = 1'b1;
            end else begin
              pend_hi = rh[W-1:0]; pend_lo = rl[W-1:0]; m_dz = 1'b0; left = W + 1;
            end
          end
        end
        m_busy = (left > 0);
      end
    end
  end

  // Per-cycle comparison of the WIDTH=16 instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      tests++;
      if (hi !== m_hi || lo !== m_lo || busy !== m_busy || done !== m_done ||
          div_by_zero !== m_dz) begin
        fails++;
        $display("FAIL cycle_model t=%0t: dut hi=%h lo=%h busy=%b done=%b dbz=%b, model hi=%h lo=%h busy=%b done=%b dbz=%b",
                 $time, hi, lo, busy, done, div_by_zero, m_hi, m_lo, m_busy, m_done, m_dz);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges from acceptance until done is visible, and cycles busy was seen.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_n++;
      tick();
      lat++;
    end
    check_lit("done_seen", {63'd0, done}, 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int lat, bn, dcnt;
    repeat (2) tick();
    check_lit("reset_hi", {48'd0, hi}, 64'h0);
    check_lit("reset_lo", {48'd0, lo}, 64'h0);
    check_lit("reset_flags", {61'd0, busy, done, div_by_zero}, 64'h0);
    reset_n = 1'b1;
    tick();

    launch(2'b01, 16'hFFFF, 16'hFFFF);
    wait_done(lat, bn);
    check_lit("multu_ffff_hi", {48'd0, hi}, 64'hFFFE);
    check_lit("multu_ffff_lo", {48'd0, lo}, 64'h0001);
    check_lit("multu_latency", 64'(lat), 64'd17);
    check_lit("multu_busy_cycles", 64'(bn), 64'd17);
    check_lit("busy_low_in_done", {63'd0, busy}, 64'd0);

    launch(2'b00, 16'hFFFD, 16'h0005);
    wait_done(lat, bn);
    check_lit("mult_neg3x5_hi", {48'd0, hi}, 64'hFFFF);
    check_lit("mult_neg3x5_lo", {48'd0, lo}, 64'hFFF1);

    // Back-to-back: next op is launched in the done cycle.
    launch(2'b10, 16'hFFF9, 16'h0002);
    check_lit("b2b_accept_busy", {63'd0, busy}, 64'd1);
    wait_done(lat, bn);
    check_lit("div_neg7_2_lo", {48'd0, lo}, 64'hFFFD);
    check_lit("div_neg7_2_hi", {48'd0, hi}, 64'hFFFF);

    launch(2'b10, 16'h8000, 16'hFFFF);
    wait_done(lat, bn);
    check_lit("div_ovf_lo", {48'd0, lo}, 64'h8000);
    check_lit("div_ovf_hi", {48'd0, hi}, 64'h0000);
    check_lit("div_ovf_dbz", {63'd0, div_by_zero}, 64'd0);

    launch(2'b11, 16'h0064, 16'h0000);
    wait_done(lat, bn);
    check_lit("dbz_latency", 64'(lat), 64'd0);
    check_lit("dbz_hi", {48'd0, hi}, 64'h0064);
    check_lit("dbz_lo", {48'd0, lo}, 64'hFFFF);
    check_lit("dbz_flag", {63'd0, div_by_zero}, 64'd1);
    check_lit("dbz_no_busy", {63'd0, busy}, 64'd0);
    tick();
    check_lit("dbz_done_pulse", {63'd0, done}, 64'd0);
    check_lit("dbz_sticky", {63'd0, div_by_zero}, 64'd1);

    launch(2'b01, 16'h0002, 16'h0003);
    check_lit("dbz_cleared_on_start", {63'd0, div_by_zero}, 64'd0);
    wait_done(lat, bn);
    check_lit("multu_2x3_lo", {48'd0, lo}, 64'h0006);
    check_lit("multu_2x3_hi", {48'd0, hi}, 64'h0000);

    // Flush mid-calculation.
    launch(2'b01, 16'h0007, 16'h0009);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dcnt = 0;
    repeat (25) begin
      if (done === 1'b1) dcnt++;
      tick();
    end
    check_lit("flush_no_done", 64'(dcnt), 64'd0);
    check_lit("flush_hi_kept", {48'd0, hi}, 64'h0000);
    check_lit("flush_lo_kept", {48'd0, lo}, 64'h0006);

    // Flush and start together in IDLE: request dropped.
    op = 2'b01; src_a = 16'h0003; src_b = 16'h0003; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check_lit("flush_start_idle_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset mid-calculation.
    launch(2'b01, 16'h0007, 16'h0009);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    check_lit("async_rst_hi", {48'd0, hi}, 64'h0);
    check_lit("async_rst_lo", {48'd0, lo}, 64'h0);
    check_lit("async_rst_flags", {61'd0, busy, done, div_by_zero}, 64'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Start and MTHI while busy are ignored.
    launch(2'b01, 16'h0003, 16'h0005);
    repeat (2) tick();
    op = 2'b11; src_a = 16'h0064; src_b = 16'h0000; start = 1'b1;
    hi_we = 1'b1; wdata = 16'hABCD;
    tick();
    start = 1'b0; hi_we = 1'b0;
    wait_done(lat, bn);
    check_lit("busy_ignore_hi", {48'd0, hi}, 64'h0000);
    check_lit("busy_ignore_lo", {48'd0, lo}, 64'h000F);
    check_lit("busy_ignore_dbz", {63'd0, div_by_zero}, 64'd0);

    // MTHI / MTLO in IDLE.
    hi_we = 1'b1; wdata = 16'h1234;
    tick();
    hi_we = 1'b0;
    check_lit("mthi", {48'd0, hi}, 64'h1234);
    lo_we = 1'b1; wdata = 16'hBEEF;
    tick();
    lo_we = 1'b0;
    check_lit("mtlo", {48'd0, lo}, 64'hBEEF);

    // MTHI alongside a start: write visible first, result overwrites at done.
    hi_we = 1'b1; wdata = 16'h5678;
    launch(2'b01, 16'h0002, 16'h0002);
    hi_we = 1'b0;
    check_lit("mthi_with_start_hi", {48'd0, hi}, 64'h5678);
    wait_done(lat, bn);
    check_lit("mthi_then_result_hi", {48'd0, hi}, 64'h0000);
    check_lit("mthi_then_result_lo", {48'd0, lo}, 64'h0004);

    // Divide by zero beats a same-cycle MTHI.
    hi_we = 1'b1; wdata = 16'h9999;
    launch(2'b11, 16'h0042, 16'h0000);
    hi_we = 1'b0;
    check_lit("dbz_beats_mthi_hi", {48'd0, hi}, 64'h0042);
    check_lit("dbz_beats_mthi_lo", {48'd0, lo}, 64'hFFFF);

    // WIDTH=8 instance.
    op8 = 2'b00; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (done8 !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    check_lit("w8_latency", 64'(lat), 64'd9);
    check_lit("w8_mult_hi", {56'd0, hi8}, 64'h40);
    check_lit("w8_mult_lo", {56'd0, lo8}, 64'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom_range(0, 3));
      src_a = pick();
      src_b = pick();
      flush = ($urandom_range(0, 49) == 0);
      hi_we = ($urandom_range(0, 9) == 0);
      lo_we = ($urandom_range(0, 9) == 0);
      wdata = 16'($urandom);
      tick();
    end
    start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (25) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Parametrised iterative multiply/divide unit with HI/LO result registers, for the pipelined MIPS core's EX stage. Accepts MULT/MULTU/DIV/DIVU requests, computes over WIDTH+1 cycles, and holds the result in architectural HI/LO registers. MTHI and MTLO write HI and LO directly. `busy` feeds the hazard unit as a stall source; `flush` lets branch/jump squash an in-flight op.

## Interface
- `WIDTH`, 16 — operand and HI/LO width; ≥ 4.
- `clk` input 1 — clock; all state changes on rising edge.
- `reset_n` input 1 — asynchronous, active-low reset.
- `start` input 1 — request; sampled only in IDLE.
- `op` input 2 — 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `src_a` input WIDTH — multiplicand / dividend.
- `src_b` input WIDTH — multiplier / divisor.
- `flush` input 1 — abort in-flight op.
- `hi_we` input 1 — MTHI.
- `lo_we` input 1 — MTLO.
- `wdata` input WIDTH — MTHI/MTLO data.
- `busy` output 1 — op in flight; pipeline must stall HI/LO consumers.
- `done` output 1 — one-cycle pulse; HI/LO hold the new result.
- `div_by_zero` output 1 — sticky flag for last op; cleared by next accepted start.
- `hi` output WIDTH — HI register; remainder or upper product.
- `lo` output WIDTH — LO register; quotient or lower product.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start`=1, `flush`=0: latch operands, then branch on op and divisor.
  - Signed ops: latch magnitudes and result signs.
  - DIV/DIVU with `src_b`=0: stay IDLE. Next edge sets HI=`src_a`, LO=all ones, `div_by_zero`=1, `done`=1.
  - Otherwise: go to CALC with counter = WIDTH-1 and clear `div_by_zero`.
- CALC: one step per cycle.
  - Multiply: radix-2 shift-add on magnitudes into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes.
  - Counter reaches 0: go to FIX.
- FIX: apply signs and write HI/LO, pulse `done`, return to IDLE.
  - MULT/MULTU: {HI,LO} = full 2·WIDTH product; MULT is two's-complement.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed divide truncates toward zero; remainder takes the dividend's sign.
  - Overflow: DIV of most-negative by -1 gives LO = most-negative, HI = 0, no flag.
- `start` while `busy`: ignored; no queuing.
- `flush` in CALC or FIX: next edge returns to IDLE; HI/LO unchanged, no `done`.
- `flush` and `start` in the same IDLE cycle: `flush` wins, request dropped.
- `hi_we`/`lo_we`: honoured only in IDLE, on the next edge.
  - A same-cycle `start` still launches; its result later overwrites.
  - Divide-by-zero with a same-cycle write: divide result wins.
  - Writes while `busy` are dropped.
- `reset_n` low, any state, asynchronous: state IDLE; `hi`, `lo`, `busy`, `done`, `div_by_zero` all 0; counter 0.

## Timing
- Start accepted at edge E0: `busy`=1 from E0 until E(WIDTH+1).
  - CALC covers edges E1..E(WIDTH); FIX updates HI/LO at E(WIDTH+1).
  - `done`=1 for the single cycle after E(WIDTH+1); `busy`=0 in that cycle.
  - For WIDTH=16: result visible 17 cycles after the accepting edge.
- Back-to-back: a new `start` is accepted in the `done` cycle.
- Divide-by-zero: `busy` never asserts; `done` and results appear one edge after acceptance.
- `busy` is registered; no combinational path from `start` or `op` to any output.
- MTHI/MTLO: value visible on `hi`/`lo` the cycle after the write edge.
- Timing is data-independent: no early termination.

## Test plan
- MULTU 0xFFFF×0xFFFF, WIDTH=16 → HI=0xFFFE, LO=0x0001; `done` exactly 17 cycles after accept; `busy` high 17 cycles.
- MULT 0xFFFD(-3)×0x0005 → HI=0xFFFF, LO=0xFFF1. Then DIV 0xFFF9(-7)÷0x0002 → LO=0xFFFD, HI=0xFFFF.
- DIV 0x8000÷0xFFFF → LO=0x8000, HI=0x0000, `div_by_zero`=0.
- DIVU 0x0064÷0x0000 → next edge HI=0x0064, LO=0xFFFF, `div_by_zero`=1, `done` pulse, `busy` never high. Following MULTU 2×3 clears the flag: LO=6, HI=0.
- MULTU started; at cycle 5 assert `flush` → no `done`, HI/LO keep prior values. Repeat with `reset_n` low at cycle 5 → all outputs 0 immediately. Repeat with `start`, `hi_we` asserted at cycle 3 → both ignored.
- IDLE: `hi_we`=1, `wdata`=0x1234 → HI=0x1234 next cycle. Same cycle as `start` MULTU 2×2 → HI=0x1234 visible, then HI=0, LO=4 at `done`.
- Regression at WIDTH=8: MULT 0x80×0x80 → HI=0x40, LO=0x00; `done` 9 cycles after accept.
